cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Shares one physical memory port between an icache and a dcache.
// The dcache wins ties, but a streak limit guarantees the icache a slot.
module cache_arbiter #(
   parameter int LINE_WIDTH   = 256,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [31:0]           i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [31:0]           d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [31:0]           pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   localparam int            SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, TURN} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [SW-1:0]         r_streak;
   logic [SW-1:0]         w_next_streak;
   logic                  r_read;
   logic                  r_write;
   logic [31:0]           r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic                  w_d_req;
   logic                  w_grant_d;
   logic                  w_grant_i;
   logic                  w_done;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_next_state  = r_state;
      w_next_streak = r_streak;
      w_d_req       = d_pmem_read | d_pmem_write;
      w_grant_d     = 1'b0;
      w_grant_i     = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_d_req && (!i_pmem_read || (r_streak < STREAK_MAX))) begin
               w_grant_d    = 1'b1;
               w_next_state = D_BUSY;
               if (!i_pmem_read)
                  w_next_streak = '0;
               else if (r_streak != STREAK_MAX)
                  w_next_streak = r_streak + SW'(1);
            end else if (i_pmem_read) begin
               w_grant_i     = 1'b1;
               w_next_state  = I_BUSY;
               w_next_streak = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (pmem_resp) begin
               w_done       = 1'b1;
               w_next_state = TURN;
            end
         end
         TURN:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments; the line-wide data register is reset too so pmem_wdata reads 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_streak <= '0;
         r_read   <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state  <= w_next_state;
         r_streak <= w_next_streak;
         if (w_grant_d) begin
            // A simultaneous read and writeback resolves to the writeback.
            r_write <= d_pmem_write;
            r_read  <= ~d_pmem_write;
            r_addr  <= d_pmem_address;
            r_wdata <= d_pmem_wdata;
         end else if (w_grant_i) begin
            r_read  <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= i_pmem_address;
            r_wdata <= '0;
         end else if (w_done) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
         end
      end
   end

   assign pmem_read    = r_read;
   assign pmem_write   = r_write;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;

   // Responses are combinational so the cache sees completion in the same cycle.
   assign i_pmem_resp  = (r_state == I_BUSY) && pmem_resp;
   assign d_pmem_resp  = (r_state == D_BUSY) && pmem_resp;
   assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
   assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_cache_arbiter;

   localparam int LW   = 256;
   localparam int MAXS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_pmem_read = 1'b0;
   logic [31:0]   i_pmem_address = '0;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read = 1'b0;
   logic          d_pmem_write = 1'b0;
   logic [31:0]   d_pmem_address = '0;
   logic [LW-1:0] d_pmem_wdata = '0;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;

   always #5 clk = ~clk;

   cache_arbiter #(.LINE_WIDTH(LW), .MAX_D_STREAK(MAXS)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the memory port, whether the one-cycle quiet gap
   // is pending, how many dcache grants in a row icache has waited through, and
   // the command captured at grant time.
   int            m_owner = 0;   // 0 none, 1 icache, 2 dcache
   bit            m_quiet = 1'b0;
   int            m_streak = 0;
   bit            m_read = 1'b0;
   bit            m_write = 1'b0;
   logic [31:0]   m_addr = '0;
   logic [LW-1:0] m_wdata = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner  <= 0;
         m_quiet  <= 1'b0;
         m_streak <= 0;
         m_read   <= 1'b0;
         m_write  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
      end else if (m_owner != 0) begin
         if (pmem_resp) begin
            m_owner <= 0;
            m_quiet <= 1'b1;
            m_read  <= 1'b0;
            m_write <= 1'b0;
         end
      end else if (m_quiet) begin
         m_quiet <= 1'b0;
      end else if ((d_pmem_read || d_pmem_write) && (!i_pmem_read || m_streak < MAXS)) begin
         m_owner  <= 2;
         m_write  <= d_pmem_write;
         m_read   <= !d_pmem_write;
         m_addr   <= d_pmem_address;
         m_wdata  <= d_pmem_wdata;
         m_streak <= i_pmem_read ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (i_pmem_read) begin
         m_owner  <= 1;
         m_read   <= 1'b1;
         m_write  <= 1'b0;
         m_addr   <= i_pmem_address;
         m_streak <= 0;
      end
   end

   always @(negedge clk) begin
      #2;
      check("pmem_read", pmem_read, m_read);
      check("pmem_write", pmem_write, m_write);
      check("i_resp", i_pmem_resp, (m_owner == 1) && pmem_resp);
      check("d_resp", d_pmem_resp, (m_owner == 2) && pmem_resp);
      check("i_rdata", i_pmem_rdata, ((m_owner == 1) && pmem_resp) ? pmem_rdata : '0);
      check("d_rdata", d_pmem_rdata, ((m_owner == 2) && pmem_resp) ? pmem_rdata : '0);
      check("cmd_excl", pmem_read && pmem_write, 1'b0);
      check("resp_excl", i_pmem_resp && d_pmem_resp, 1'b0);
      if (m_owner != 0) check("pmem_address", pmem_address, m_addr);
      if (m_write) check("pmem_wdata", pmem_wdata, m_wdata);
   end

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic tick1();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cmd(input string name);
      int k;
      k = 0;
      while (!(pmem_read || pmem_write) && k < 50) begin
         tick1();
         k++;
      end
      check({name, "_cmd_seen"}, pmem_read || pmem_write, 1'b1);
   endtask

   initial begin
      logic [9:0]    seq;
      logic [LW-1:0] pat;
      seq = '0;

      // Reset values
      #1 rst = 1'b1;
      #1;
      check("rst_pmem_read", pmem_read, 1'b0);
      check("rst_pmem_write", pmem_write, 1'b0);
      check("rst_pmem_address", pmem_address, 32'h0);
      check("rst_pmem_wdata", pmem_wdata, '0);
      check("rst_i_resp", i_pmem_resp, 1'b0);
      check("rst_d_resp", d_pmem_resp, 1'b0);
      tick1();
      tick1();
      rst = 1'b0;

      // Lone icache fill with a slow memory
      tick1();
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_1000;
      tick1();
      check("t1_read_next_cycle", pmem_read, 1'b1);
      check("t1_write_low", pmem_write, 1'b0);
      check("t1_address", pmem_address, 32'h0000_1000);
      repeat (4) begin
         tick1();
         check("t1_read_held", pmem_read, 1'b1);
         check("t1_no_early_resp", i_pmem_resp, 1'b0);
      end
      tick1();
      pat = {8{32'hC0DE_0001}};
      pmem_resp = 1'b1;
      pmem_rdata = pat;
      #1;
      check("t1_i_resp", i_pmem_resp, 1'b1);
      check("t1_i_rdata", i_pmem_rdata, pat);
      check("t1_d_rdata_zero", d_pmem_rdata, '0);
      tick1();
      i_pmem_read = 1'b0;
      #1;
      check("t1_turn_read_low", pmem_read, 1'b0);
      check("t1_turn_resp_ignored", i_pmem_resp, 1'b0);
      tick1();
      pmem_resp = 1'b0;

      // Simultaneous requests: dcache first, then icache
      tick1();
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_0100;
      d_pmem_read = 1'b1;
      d_pmem_address = 32'h0000_0200;
      wait_cmd("t2_first");
      check("t2_d_first_addr", pmem_address, 32'h0000_0200);
      pmem_resp = 1'b1;
      pmem_rdata = {8{32'hD00D_0002}};
      #1;
      check("t2_d_resp", d_pmem_resp, 1'b1);
      check("t2_i_not_resp", i_pmem_resp, 1'b0);
      tick1();
      pmem_resp = 1'b0;
      d_pmem_read = 1'b0;
      #1;
      check("t2_turn", pmem_read, 1'b0);
      wait_cmd("t2_second");
      check("t2_i_second_addr", pmem_address, 32'h0000_0100);
      pmem_resp = 1'b1;
      #1;
      check("t2_i_resp", i_pmem_resp, 1'b1);
      tick1();
      pmem_resp = 1'b0;
      i_pmem_read = 1'b0;

      // Continuous dcache writebacks against a waiting icache
      tick1();
      d_pmem_write = 1'b1;
      d_pmem_address = 32'h0000_5000;
      d_pmem_wdata = rand_line();
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_6000;
      for (int k = 0; k < 10; k++) begin
         wait_cmd("t3_grant");
         pmem_resp = 1'b1;
         #1;
         seq = {seq[8:0], d_pmem_resp};
         tick1();
         pmem_resp = 1'b0;
      end
      d_pmem_write = 1'b0;
      i_pmem_read = 1'b0;
      check("t3_streak_pattern", seq, 10'b11110_11110);

      // Read+write together, then address changes mid-transaction
      tick1();
      tick1();
      d_pmem_read = 1'b1;
      d_pmem_write = 1'b1;
      d_pmem_wdata = {32{8'hA5}};
      d_pmem_address = 32'h0000_2040;
      wait_cmd("t4");
      check("t4_write_only", pmem_write, 1'b1);
      check("t4_no_read", pmem_read, 1'b0);
      check("t4_wdata", pmem_wdata, {32{8'hA5}});
      check("t4_address", pmem_address, 32'h0000_2040);
      d_pmem_address = 32'h9999_0000;
      d_pmem_wdata = '0;
      repeat (3) begin
         tick1();
         check("t4_address_latched", pmem_address, 32'h0000_2040);
         check("t4_wdata_latched", pmem_wdata, {32{8'hA5}});
      end
      pmem_resp = 1'b1;
      #1;
      check("t4_d_resp", d_pmem_resp, 1'b1);
      tick1();
      pmem_resp = 1'b0;
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;

      // Reset in the middle of a dcache transaction
      tick1();
      d_pmem_read = 1'b1;
      d_pmem_address = 32'h0000_3000;
      wait_cmd("t5");
      check("t5_address", pmem_address, 32'h0000_3000);
      tick1();
      d_pmem_read = 1'b0;
      rst = 1'b1;
      pmem_resp = 1'b1;
      pmem_rdata = {8{32'hBAD0_0005}};
      #1;
      check("t5_rst_read", pmem_read, 1'b0);
      check("t5_rst_write", pmem_write, 1'b0);
      check("t5_rst_address", pmem_address, 32'h0);
      check("t5_rst_d_resp", d_pmem_resp, 1'b0);
      check("t5_rst_d_rdata", d_pmem_rdata, '0);
      tick1();
      check("t5_rst_d_resp_held", d_pmem_resp, 1'b0);
      tick1();
      rst = 1'b0;
      pmem_resp = 1'b0;
      tick1();
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_4000;
      wait_cmd("t5_after");
      check("t5_after_address", pmem_address, 32'h0000_4000);
      pat = {8{32'h600D_0005}};
      pmem_resp = 1'b1;
      pmem_rdata = pat;
      #1;
      check("t5_after_i_resp", i_pmem_resp, 1'b1);
      check("t5_after_i_rdata", i_pmem_rdata, pat);
      tick1();
      pmem_resp = 1'b0;
      i_pmem_read = 1'b0;

      // Random traffic, including stray responses and occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 299) == 0);
         i_pmem_read    = ($urandom_range(0, 2) != 0);
         i_pmem_address = $urandom;
         d_pmem_read    = ($urandom_range(0, 1) == 0);
         d_pmem_write   = ($urandom_range(0, 2) == 0);
         d_pmem_address = $urandom;
         d_pmem_wdata   = rand_line();
         pmem_resp      = ($urandom_range(0, 2) == 0);
         pmem_rdata     = rand_line();
      end
      @(negedge clk);
      rst = 1'b0;
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;
      pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
